// File: rtl/fir_sym_serial_pkg.sv
// Shared types and width helpers for the serial symmetric FIR.
// State encodings stay plain constants so older netlists keep matching state values.
package fir_sym_serial_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_MAC  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Accumulator wide enough for NTAPS/2 full-scale folded products.
   function automatic int acc_w(input int data_w, input int coef_w, input int ntaps);
      return data_w + coef_w + 1 + $clog2(ntaps / 2);
   endfunction

   function automatic int round_bias(input int frac);
      return 2 ** (frac - 1);
   endfunction

endpackage

// File: rtl/fir_sym_serial_if.sv
// Sample stream, coefficient write port and result signals of the serial FIR.
interface fir_sym_serial_if #(
   parameter int NTAPS  = 32,
   parameter int DATA_W = 16,
   parameter int COEF_W = 16
);
   localparam int CA_W = $clog2(NTAPS / 2);

   logic                     in_valid;
   logic signed [DATA_W-1:0] in_sample;
   logic                     in_ready;
   logic                     coef_we;
   logic [CA_W-1:0]          coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_sample;
   logic                     out_sat;
   logic                     overrun;

   modport master (
      output in_valid, in_sample, coef_we, coef_addr, coef_data,
      input  in_ready, out_valid, out_sample, out_sat, overrun
   );

   modport slave (
      input  in_valid, in_sample, coef_we, coef_addr, coef_data,
      output in_ready, out_valid, out_sample, out_sat, overrun
   );
endinterface

// File: rtl/fir_sym_serial_round_sat.sv
// Round-half-up of the accumulator down to sample scale, then clamp to the sample range.
module fir_round_sat
   import fir_sym_serial_pkg::*;
#(
   parameter int ACC_W  = 37,
   parameter int DATA_W = 16,
   parameter int FRAC   = 15
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [DATA_W-1:0] sample,
   output logic                     sat
);
   // One guard bit keeps the bias addition from wrapping.
   localparam int SUM_W = ACC_W + 1;
   localparam int SH_W  = SUM_W - FRAC;

   localparam logic signed [SUM_W-1:0] BIAS  = SUM_W'(round_bias(FRAC));
   localparam logic signed [SH_W-1:0]  MAX_V = SH_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [SH_W-1:0]  MIN_V = SH_W'(-(2 ** (DATA_W - 1)));

   logic signed [SUM_W-1:0] sum;
   logic signed [SH_W-1:0]  shifted;

   always_comb begin
      sum     = SUM_W'(acc) + BIAS;
      shifted = SH_W'(sum >>> FRAC);
      sat     = (shifted > MAX_V) || (shifted < MIN_V);
      if (sat)
         sample = shifted[SH_W-1] ? DATA_W'(MIN_V) : DATA_W'(MAX_V);
      else
         sample = DATA_W'(shifted);
   end

endmodule

// File: rtl/fir_sym_serial.sv
// Time-multiplexed symmetric FIR: one multiplier, taps i and NTAPS-1-i folded before the multiply.
//
// state   | meaning
// IDLE    | ready for a sample; coefficient writes accepted
// MAC     | NTAPS/2 folded multiply-accumulate cycles
// DONE    | round/saturate accumulator, present result
module fir_sym_serial
   import fir_sym_serial_pkg::*;
#(
   parameter int NTAPS  = 32,
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int FRAC   = 15
) (
   input logic              clk,
   input logic              reset_n,
   fir_sym_serial_if.slave  bus
);
   localparam int NH     = NTAPS / 2;
   localparam int AW     = $clog2(NTAPS);
   localparam int KW     = $clog2(NH);
   localparam int ACC_W  = acc_w(DATA_W, COEF_W, NTAPS);
   localparam int PAIR_W = DATA_W + 1;
   localparam int PROD_W = PAIR_W + COEF_W;

   state_t                   state;
   logic [AW-1:0]            wr_ptr, rd_a, rd_b;
   logic [KW-1:0]            k;
   logic signed [DATA_W-1:0] dly [NTAPS];
   logic signed [COEF_W-1:0] coef [NH];
   logic signed [ACC_W-1:0]  acc;

   logic signed [PAIR_W-1:0] pair;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;

   logic                     out_valid_q, out_sat_q;
   logic signed [DATA_W-1:0] out_sample_q;
   logic signed [DATA_W-1:0] rs_sample;
   logic                     rs_sat;

   // Explicit wrap so a non-power-of-two NTAPS stays legal.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(NTAPS - 1)) ? '0 : p + AW'(1);
   endfunction

   function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
      return (p == '0) ? AW'(NTAPS - 1) : p - AW'(1);
   endfunction

   assign pair     = PAIR_W'(dly[rd_a]) + PAIR_W'(dly[rd_b]);
   assign prod     = pair * coef[k];
   assign prod_ext = ACC_W'(prod);

   fir_round_sat #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .FRAC   (FRAC)
   ) u_round_sat (
      .acc    (acc),
      .sample (rs_sample),
      .sat    (rs_sat)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         wr_ptr       <= '0;
         rd_a         <= '0;
         rd_b         <= '0;
         k            <= '0;
         acc          <= '0;
         out_valid_q  <= 1'b0;
         out_sample_q <= '0;
         out_sat_q    <= 1'b0;
         for (int i = 0; i < NTAPS; i++) dly[i] <= '0;
         for (int i = 0; i < NH; i++) coef[i] <= '0;
      end else begin
         out_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A write landing with an accept is already in the bank for that sample.
               if (bus.coef_we) coef[bus.coef_addr] <= bus.coef_data;
               if (bus.in_valid) begin
                  dly[wr_ptr] <= bus.in_sample;
                  acc         <= '0;
                  rd_a        <= wr_ptr;
                  rd_b        <= ptr_inc(wr_ptr);
                  k           <= '0;
                  wr_ptr      <= ptr_inc(wr_ptr);
                  state       <= ST_MAC;
               end
            end
            ST_MAC: begin
               acc  <= acc + prod_ext;
               rd_a <= ptr_dec(rd_a);
               rd_b <= ptr_inc(rd_b);
               k    <= k + KW'(1);
               if (k == KW'(NH - 1)) state <= ST_DONE;
            end
            ST_DONE: begin
               out_sample_q <= rs_sample;
               out_sat_q    <= rs_sat;
               out_valid_q  <= 1'b1;
               state        <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (state == ST_IDLE);
   assign bus.overrun    = bus.in_valid & (state != ST_IDLE);
   assign bus.out_valid  = out_valid_q;
   assign bus.out_sample = out_sample_q;
   assign bus.out_sat    = out_sat_q;

endmodule
